// File: rtl/ram_if.sv
// Request/response bundle between a RAM client (master) and ram_responder (slave).
// Addresses are full 32-bit words; the responder decides how many bits it decodes.
interface ram_if;
    logic        ram_r;
    logic [31:0] ram_r_addr;
    logic        ram_w;
    logic [31:0] ram_w_addr;
    logic [31:0] ram_w_line;
    logic [31:0] ram_r_line;
    logic        ram_r_valid;
    logic        ram_busy;
    logic        ram_err;

    modport master (
        output ram_r, ram_r_addr, ram_w, ram_w_addr, ram_w_line,
        input  ram_r_line, ram_r_valid, ram_busy, ram_err
    );

    modport slave (
        input  ram_r, ram_r_addr, ram_w, ram_w_addr, ram_w_line,
        output ram_r_line, ram_r_valid, ram_busy, ram_err
    );
endinterface

// File: rtl/ram_responder.sv
// Single-port word RAM with a posted-write FIFO: reads win the array port, the
// buffer drains on idle cycles, and reads forward from pending writes.
module ram_responder #(
    parameter int ADDR_BITS = 10,
    parameter int WB_DEPTH  = 4
) (
    input logic   clk,
    input logic   rst,
    ram_if.slave  bus
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    typedef logic [ADDR_BITS-1:0] idx_t;

    logic [31:0]      mem     [2**ADDR_BITS];
    idx_t             wb_addr [WB_DEPTH];
    logic [31:0]      wb_data [WB_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next;

    idx_t        r_idx, w_idx;
    logic        full, drain, accept, drop;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [PTR_W-1:0] slot;

    assign r_idx = bus.ram_r_addr[ADDR_BITS-1:0];
    assign w_idx = bus.ram_w_addr[ADDR_BITS-1:0];

    // Upper address bits are deliberately ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ram_r_addr[31:ADDR_BITS], bus.ram_w_addr[31:ADDR_BITS]};

    assign full   = (count == CNT_W'(WB_DEPTH));
    assign drain  = !bus.ram_r && (count != '0);
    assign accept = bus.ram_w && (!full || drain);
    assign drop   = bus.ram_w && full && bus.ram_r;

    // Walk oldest to youngest so the youngest matching entry overrides; an
    // accepted same-cycle write beats every buffered entry.
    // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (wb_addr[slot] == r_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[slot];
            end
        end
        if (accept && (w_idx == r_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = bus.ram_w_line;
        end
    end

    always_comb begin
        count_next = count;
        unique case ({accept, drain})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage arrays carry no reset so they map onto RAM; reset only gates their writes.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            wb_addr[wr_ptr] <= w_idx;
            wb_data[wr_ptr] <= bus.ram_w_line;
        end
        if (!rst && drain) begin
            mem[wb_addr[rd_ptr]] <= wb_data[rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            bus.ram_r_line  <= '0;
            bus.ram_r_valid <= 1'b0;
            bus.ram_busy    <= 1'b0;
            bus.ram_err     <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain)  rd_ptr <= rd_ptr + PTR_W'(1);
            count           <= count_next;
            bus.ram_busy    <= (count_next == CNT_W'(WB_DEPTH));
            bus.ram_err     <= bus.ram_err | drop;
            bus.ram_r_valid <= bus.ram_r;
            if (bus.ram_r) begin
                bus.ram_r_line <= fwd_hit ? fwd_data : mem[r_idx];
            end
        end
    end
endmodule
